// File: rtl/multi_noc_bypass_ring_pkg.sv
// Shared types and elaboration helpers for the multi-plane bypass ring.
// Default link widths stand in for the node-level WIDTH_PORT / WIDTH_PV constants.
package multi_noc_bypass_ring_pkg;

  localparam int WIDTH_PORT_DEF = 8;
  localparam int WIDTH_PV_DEF   = 4;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } dir_state_e;

  function automatic int ring_prev(input int i, input int n);
    return (i + n - 1) % n;
  endfunction

  function automatic int ring_next(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/multi_noc_bypass_ring_link_fifo.sv
// One elastic ring hop: DEPTH-entry FWFT buffer with registered storage,
// wrapping pointers, occupancy count and an external write inhibit.
module bypass_link_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld_in,
  input  logic             wr_inhibit_in,
  input  logic [WIDTH-1:0] wr_data_in,
  input  logic             rd_rdy_in,
  output logic [WIDTH-1:0] rd_data_out,
  output logic             rd_vld_out,
  output logic             full_out,
  output logic [CNT_W-1:0] occ_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             wr_en_s, rd_en_s;

  // Full and valid derive from registered occupancy only, so no input reaches an output.
  assign full_out    = (occ_q == CNT_W'(DEPTH));
  assign rd_vld_out  = (occ_q != {CNT_W{1'b0}});
  assign rd_data_out = mem_q[rptr_q];
  assign occ_out     = occ_q;

  assign wr_en_s = wr_vld_in && !full_out && !wr_inhibit_in;
  assign rd_en_s = rd_vld_out && rd_rdy_in;

  // Next storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (wr_en_s) begin
      mem_d[wptr_q] = wr_data_in;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_en_s) begin
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset discards all buffered flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      occ_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/multi_noc_bypass_ring.sv
// Bypass ring linking NUM_PLANES router planes through elastic link buffers,
// with a drain-then-switch FSM for lossless runtime direction changes.
module multi_noc_bypass_ring
  import multi_noc_bypass_ring_pkg::*;
#(
  parameter int NUM_PLANES = 2,
  parameter int WIDTH_PORT = WIDTH_PORT_DEF,
  parameter int WIDTH_PV   = WIDTH_PV_DEF,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PLANES*WIDTH_PORT-1:0] byp_in,
  input  logic [NUM_PLANES*WIDTH_PV-1:0]   byp_pv_in,
  input  logic [NUM_PLANES-1:0]            byp_vld_in,
  output logic [NUM_PLANES-1:0]            byp_full,
  output logic [NUM_PLANES*WIDTH_PORT-1:0] byp_out,
  output logic [NUM_PLANES*WIDTH_PV-1:0]   byp_pv_out,
  output logic [NUM_PLANES-1:0]            byp_vld_out,
  input  logic [NUM_PLANES-1:0]            byp_rdy_in,
  input  logic                             ring_dir,
  output logic                             ring_dir_active,
  output logic [NUM_PLANES*CNT_W-1:0]      link_occ
);

  localparam int LW = WIDTH_PORT + WIDTH_PV;

  dir_state_e              state_q, state_d;
  logic                    dir_q, dir_d;
  logic                    switch_pending_s;
  logic                    all_empty_s;
  logic [NUM_PLANES-1:0]   fifo_full_s;

  assign all_empty_s     = (link_occ == {(NUM_PLANES*CNT_W){1'b0}});
  assign ring_dir_active = dir_q;

  // Direction FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Direction FSM next state; a reverted request still waits for empty.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      ST_RUN: begin
        if (ring_dir != dir_q) state_d = ST_DRAIN;
        else                   state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (all_empty_s) begin
          state_d = ST_RUN;
          dir_d   = ring_dir;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Direction FSM outputs.
  always_comb begin
    switch_pending_s = 1'b0;
    case (state_q)
      ST_DRAIN: switch_pending_s = 1'b1;
      default:  switch_pending_s = 1'b0;
    endcase
  end

  for (genvar j = 0; j < NUM_PLANES; j++) begin : g_link
    localparam int PREV = ring_prev(j, NUM_PLANES);
    localparam int NEXT = ring_next(j, NUM_PLANES);

    logic          src_vld_s;
    logic [LW-1:0] src_data_s;
    logic [LW-1:0] head_s;

    // dir 0: plane j-1 feeds j; dir 1: plane j+1 feeds j.
    assign src_vld_s  = dir_q ? byp_vld_in[NEXT] : byp_vld_in[PREV];
    assign src_data_s = dir_q ? {byp_in[NEXT*WIDTH_PORT +: WIDTH_PORT], byp_pv_in[NEXT*WIDTH_PV +: WIDTH_PV]}
                              : {byp_in[PREV*WIDTH_PORT +: WIDTH_PORT], byp_pv_in[PREV*WIDTH_PV +: WIDTH_PV]};

    // Plane j sees back-pressure from the buffer it currently feeds.
    assign byp_full[j] = (dir_q ? fifo_full_s[PREV] : fifo_full_s[NEXT]) | switch_pending_s;

    bypass_link_fifo #(
      .WIDTH (LW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk           (clk),
      .rst_n         (reset),
      .wr_vld_in     (src_vld_s),
      .wr_inhibit_in (switch_pending_s),
      .wr_data_in    (src_data_s),
      .rd_rdy_in     (byp_rdy_in[j]),
      .rd_data_out   (head_s),
      .rd_vld_out    (byp_vld_out[j]),
      .full_out      (fifo_full_s[j]),
      .occ_out       (link_occ[j*CNT_W +: CNT_W])
    );

    assign byp_out[j*WIDTH_PORT +: WIDTH_PORT] = head_s[LW-1 -: WIDTH_PORT];
    assign byp_pv_out[j*WIDTH_PV +: WIDTH_PV]  = head_s[WIDTH_PV-1:0];
  end

endmodule

// File: tb/tb_multi_noc_bypass_ring.sv
// Directed self-checking bench for multi_noc_bypass_ring (4 planes, depth 4).
module tb_multi_noc_bypass_ring;

  localparam int N  = 4;
  localparam int WP = 8;
  localparam int WV = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*WP-1:0] byp_in;
  logic [N*WV-1:0] byp_pv_in;
  logic [N-1:0]    byp_vld_in;
  logic [N-1:0]    byp_full;
  logic [N*WP-1:0] byp_out;
  logic [N*WV-1:0] byp_pv_out;
  logic [N-1:0]    byp_vld_out;
  logic [N-1:0]    byp_rdy_in;
  logic            ring_dir;
  logic            ring_dir_active;
  logic [N*CW-1:0] link_occ;

  int checks = 0;
  int errors = 0;

  multi_noc_bypass_ring #(
    .NUM_PLANES (N),
    .WIDTH_PORT (WP),
    .WIDTH_PV   (WV),
    .DEPTH      (D),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .byp_in          (byp_in),
    .byp_pv_in       (byp_pv_in),
    .byp_vld_in      (byp_vld_in),
    .byp_full        (byp_full),
    .byp_out         (byp_out),
    .byp_pv_out      (byp_pv_out),
    .byp_vld_out     (byp_vld_out),
    .byp_rdy_in      (byp_rdy_in),
    .ring_dir        (ring_dir),
    .ring_dir_active (ring_dir_active),
    .link_occ        (link_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int p, input logic [7:0] f, input logic [3:0] pv);
    byp_in[p*WP +: WP]    = f;
    byp_pv_in[p*WV +: WV] = pv;
    byp_vld_in[p]         = 1'b1;
  endtask

  function automatic logic [7:0] flit(input int p);
    return byp_out[p*WP +: WP];
  endfunction

  function automatic logic [2:0] occ(input int p);
    return link_occ[p*CW +: CW];
  endfunction

  initial begin
    // Reset with random inputs
    reset      = 1'b0;
    byp_in     = $urandom;
    byp_pv_in  = 16'($urandom);
    byp_vld_in = 4'($urandom);
    byp_rdy_in = 4'($urandom);
    ring_dir   = 1'($urandom);
    repeat (3) tick();
    chk("rst_out",  64'(byp_out), 64'h0);
    chk("rst_pv",   64'(byp_pv_out), 64'h0);
    chk("rst_vld",  64'(byp_vld_out), 64'h0);
    chk("rst_full", 64'(byp_full), 64'h0);
    chk("rst_occ",  64'(link_occ), 64'h0);
    chk("rst_dir",  64'(ring_dir_active), 64'h0);
    byp_in = '0; byp_pv_in = '0; byp_vld_in = '0; byp_rdy_in = '0; ring_dir = 1'b0;
    #2 reset = 1'b1;
    repeat (2) tick();
    chk("post_rst_vld", 64'(byp_vld_out), 64'h0);
    chk("post_rst_occ", 64'(link_occ), 64'h0);

    // Single hop 0 -> 1
    offer(0, 8'h1A, 4'h3);
    tick();
    byp_vld_in = '0;
    chk("hop_vld",  64'(byp_vld_out), 64'h2);
    chk("hop_flit", 64'(flit(1)), 64'h1A);
    chk("hop_pv",   64'(byp_pv_out[1*WV +: WV]), 64'h3);
    chk("hop_occ",  64'(occ(1)), 64'd1);
    byp_rdy_in[1] = 1'b1;
    tick();
    byp_rdy_in[1] = 1'b0;
    chk("hop_pop_occ", 64'(occ(1)), 64'd0);
    chk("hop_pop_vld", 64'(byp_vld_out), 64'h0);

    // Fill to DEPTH with consumer stalled
    for (int i = 0; i < 4; i++) begin
      offer(0, 8'(8'h10 + i), 4'(i));
      tick();
    end
    chk("fill_occ",  64'(occ(1)), 64'd4);
    chk("fill_full", 64'(byp_full), 64'h1);
    offer(0, 8'h14, 4'h4);
    tick();
    chk("drop_occ",  64'(occ(1)), 64'd4);
    chk("drop_head", 64'(flit(1)), 64'h10);

    // Read+write at full: write blocked
    offer(0, 8'h15, 4'h5);
    byp_rdy_in[1] = 1'b1;
    tick();
    chk("fullrw_occ",  64'(occ(1)), 64'd3);
    chk("fullrw_head", 64'(flit(1)), 64'h11);
    chk("fullrw_full", 64'(byp_full), 64'h0);
    byp_vld_in = '0;
    tick();
    chk("pop_occ2", 64'(occ(1)), 64'd2);
    // Read+write at occ 2: occ unchanged
    offer(0, 8'h16, 4'h6);
    tick();
    byp_vld_in = '0;
    chk("rw2_occ",  64'(occ(1)), 64'd2);
    chk("rw2_head", 64'(flit(1)), 64'h13);
    tick();
    chk("order_head", 64'(flit(1)), 64'h16);
    chk("order_pv",   64'(byp_pv_out[1*WV +: WV]), 64'h6);
    tick();
    chk("drain_occ1", 64'(occ(1)), 64'd0);
    byp_rdy_in = '0;

    // Direction switch with 2 flits in buffer 2
    offer(1, 8'h21, 4'h1);
    tick();
    offer(1, 8'h22, 4'h2);
    tick();
    byp_vld_in = '0;
    chk("sw_occ2", 64'(occ(2)), 64'd2);
    ring_dir = 1'b1;
    tick();
    chk("sw_full", 64'(byp_full), 64'hF);
    chk("sw_dir0", 64'(ring_dir_active), 64'h0);
    offer(1, 8'h23, 4'h3);
    tick();
    byp_vld_in = '0;
    chk("sw_nowr", 64'(occ(2)), 64'd2);
    byp_rdy_in[2] = 1'b1;
    tick();
    chk("sw_head", 64'(flit(2)), 64'h22);
    tick();
    byp_rdy_in[2] = 1'b0;
    chk("sw_empty", 64'(link_occ), 64'h0);
    chk("sw_dir_hold",  64'(ring_dir_active), 64'h0);
    chk("sw_full_hold", 64'(byp_full), 64'hF);
    tick();
    chk("sw_dir1",  64'(ring_dir_active), 64'h1);
    chk("sw_full0", 64'(byp_full), 64'h0);
    offer(2, 8'h2C, 4'h5);
    tick();
    byp_vld_in = '0;
    chk("new_vld",  64'(byp_vld_out), 64'h2);
    chk("new_flit", 64'(flit(1)), 64'h2C);

    // Reset mid-drain with buffers partly full
    offer(3, 8'h31, 4'h1);
    tick();
    offer(3, 8'h32, 4'h2);
    tick();
    byp_vld_in = '0;
    chk("mid_occ", 64'(link_occ), 64'({3'd0, 3'd2, 3'd1, 3'd0}));
    ring_dir = 1'b0;
    tick();
    chk("mid_drain", 64'(byp_full), 64'hF);
    #2 reset = 1'b0;
    #1;
    chk("arst_occ",  64'(link_occ), 64'h0);
    chk("arst_vld",  64'(byp_vld_out), 64'h0);
    chk("arst_out",  64'(byp_out), 64'h0);
    chk("arst_full", 64'(byp_full), 64'h0);
    chk("arst_dir",  64'(ring_dir_active), 64'h0);
    #1 reset = 1'b1;
    tick();
    chk("rerun_full", 64'(byp_full), 64'h0);
    chk("rerun_dir",  64'(ring_dir_active), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_noc_bypass_ring.md
# multi_noc_bypass_ring

Parametrised bypass interconnect for a multi-plane bufferless NoC node. It links NUM_PLANES router planes (topBLESS instances) in a ring: each plane's bypass output feeds the next plane's bypass input. Unlike a direct wire, every hop goes through a DEPTH-entry elastic buffer with valid/ready handshake. Ring direction is selectable at runtime and switches without loss. The block sits in the node top level, between the router planes.

## Interface
- NUM_PLANES, 2: number of router planes and ring links (≥2).
- WIDTH_PORT, `WIDTH_PORT: flit width per link.
- WIDTH_PV, `WIDTH_PV: productive-vector width per link.
- DEPTH, 4: entries per link buffer (≥1, need not be a power of two).
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- byp_in  in  NUM_PLANES*WIDTH_PORT  bypass flit from plane i, in slice i.
- byp_pv_in  in  NUM_PLANES*WIDTH_PV  PV accompanying byp_in.
- byp_vld_in  in  NUM_PLANES  plane i offers a flit.
- byp_full  out  NUM_PLANES  plane i must not offer; a flit offered while high is dropped.
- byp_out  out  NUM_PLANES*WIDTH_PORT  bypass flit delivered to plane i.
- byp_pv_out  out  NUM_PLANES*WIDTH_PV  PV delivered to plane i.
- byp_vld_out  out  NUM_PLANES  byp_out[i] is valid.
- byp_rdy_in  in  NUM_PLANES  plane i consumes byp_out[i] this cycle.
- ring_dir  in  1  requested direction: 0 = plane i feeds i+1 mod N; 1 = plane i feeds i−1 mod N.
- ring_dir_active  out  1  direction currently in force.
- link_occ  out  NUM_PLANES*CNT_W  occupancy of the buffer feeding plane i.

## Operation
- One buffer per destination plane j. Its source is plane (j−1) mod N when ring_dir_active=0, and (j+1) mod N when ring_dir_active=1.
- Write: src valid && !byp_full[src]. Writes {flit, PV} at wptr. wptr wraps from DEPTH−1 to 0.
- Read: byp_vld_out[j] && byp_rdy_in[j]. Pops the head entry. rptr wraps the same way.
- Output is first-word-fall-through from registered storage. byp_vld_out[j] = (occ_j ≠ 0). Data is the head entry and holds steady until popped.
- byp_full[src] = (occ of its destination buffer == DEPTH) || switch_pending. It is computed from registered state only.
- At full, a simultaneous read does not enable a write in the same cycle. At non-full, a simultaneous read and write leaves occ unchanged.
- Direction FSM, states RUN and DRAIN:
  - RUN: if ring_dir ≠ ring_dir_active, go to DRAIN. switch_pending=1 from the next cycle.
  - DRAIN: no writes accepted. Reads continue. When all occ == 0, load ring_dir_active ← ring_dir and return to RUN. If ring_dir reverts to ring_dir_active during DRAIN, still wait for empty, then return to RUN with no change.
- Occupancy arithmetic is unsigned in CNT_W bits. occ never exceeds DEPTH and never underflows, because a read requires valid.
- Reset value of every output:
  - byp_out, byp_pv_out = 0.
  - byp_vld_out = 0.
  - byp_full = 0.
  - link_occ = 0.
  - ring_dir_active = 0; FSM in RUN.
  - Pointers are cleared.
  - Reset mid-operation discards all buffered flits immediately (asynchronous).

## Timing
- Latency: a flit written at edge t into an empty buffer has byp_vld_out high after edge t, i.e. it is consumable in cycle t+1.
- Throughput: 1 flit/cycle/link when the consumer is always ready.
- byp_full rises the cycle after the write that fills the buffer. It falls the cycle after the first pop.
- Direction switch: DRAIN is entered one cycle after the mismatch is sampled. ring_dir_active changes one cycle after all buffers are observed empty. Writes in the new direction start the following cycle.
- No combinational path from byp_rdy_in or byp_vld_in to any output.

## Structure
- Shared constants WIDTH_PORT and WIDTH_PV come from global.v. Add `WIDTH_BYP_OCC there only if other blocks need it.
- One sub-module, bypass_link_fifo, with parameters WIDTH, DEPTH, CNT_W. It holds storage, pointers, occ, vld/full and a write-inhibit input. The top generates NUM_PLANES instances, plus the source mux and the direction FSM.

## Test plan
- Reset: hold reset=0 with random inputs. All outputs must be 0 and ring_dir_active=0. Release reset; outputs stay 0 until the first write.
- Single hop, N=2: plane 0 writes flit 0x1A with PV 0x3 at t. byp_out[1]=0x1A with vld in cycle t+1. link_occ[1] returns to 0 after the pop.
- Fill/backpressure, DEPTH=4, byp_rdy_in[1]=0: four writes give occ=4 and byp_full[0]=1. A fifth offer is dropped. Release ready: pop order is strictly FIFO.
- Full with simultaneous read and write: the write is blocked that cycle and occ goes 4→3. At occ=2, a simultaneous read and write keeps occ=2 and preserves order.
- Direction switch, N=4 with 2 flits in buffer 2: toggle ring_dir. byp_full is all 1 until the flits drain. ring_dir_active flips one cycle after empty. The next flit from plane 2 arrives at plane 1.
- Reset mid-operation: with buffers half full and DRAIN active, assert reset. Everything clears within the same cycle and returns to RUN with direction 0.
